mar_arb: RTL
============

MAR_ARB -- requirements
Module: mar_arb

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read wait cycles after MAR load; legal range 1..15.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 FETCH_REQ  input  1  instruction-fetch request; MAR is to be loaded from PC.
REQ-005 OPER_REQ  input  1  operand request; MAR is to be loaded from MBR[7:0].
REQ-006 LD_MAR_PC  output  1  MAR load-from-PC strobe; drives control word bit CON[1].
REQ-007 LD_MAR_MBR  output  1  MAR load-from-MBR strobe; drives control word bit CON[8].
REQ-008 MEM_RD  output  1  memory read enable.
REQ-009 FETCH_ACK  output  1  one-cycle completion pulse to the fetch requester.
REQ-010 OPER_ACK  output  1  one-cycle completion pulse to the operand requester.
REQ-011 GNT  output  2  current owner: 00 none, 01 fetch, 10 operand.
REQ-012 BUSY  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, READ and ACK, held in a registered state; all outputs SHALL be decoded from state and owner only (Moore).
REQ-014 IDLE: if either request is high, SHALL latch the winner into the owner register and go to LOAD; otherwise SHALL stay in IDLE with GNT=00.
REQ-015 LOAD (exactly 1 cycle): SHALL assert LD_MAR_PC for a fetch owner or LD_MAR_MBR for an operand owner, never both; SHALL load the latency counter with MEM_LAT.
REQ-016 READ (exactly MEM_LAT cycles): SHALL assert MEM_RD and decrement the counter each cycle; SHALL go to ACK when the counter reaches 1.
REQ-017 ACK (exactly 1 cycle): SHALL assert only the owner's ACK, then SHALL go to IDLE.
REQ-018 Latency: with a request high in IDLE cycle 0, LOAD SHALL occupy cycle 1, READ cycles 2..MEM_LAT+1 and ACK cycle MEM_LAT+2; the minimum cycle-to-cycle spacing between transactions SHALL be MEM_LAT+3.
REQ-019 Each requester SHALL hold its REQ until its ACK and SHALL drop REQ in the cycle after ACK; the arbiter SHALL sample requests only in IDLE.
REQ-020 If a request drops after its grant, the transaction SHALL still complete and be acknowledged (no abort).
REQ-021 A request that arrives while BUSY SHALL be held off, without loss, until IDLE.
REQ-022 GNT SHALL be stable from LOAD through ACK.

Reset
REQ-023 While RST is low, the block SHALL immediately enter IDLE, clear the owner register and counter, and drive all outputs to 0, including mid-transaction.
REQ-024 After RST is released, the first request SHALL be sampled no earlier than the first rising edge with RST high.

Configuration
REQ-025 Without MAR_ARB_RR_EN: on simultaneous requests, OPER_REQ SHALL win (fixed priority).
REQ-026 With MAR_ARB_RR_EN: a last-owner flag SHALL exist, reset to operand.
- On simultaneous requests, the requester that was not last owner SHALL win.
- A single request SHALL always win.

Structure
REQ-027 A shared package mar_arb_pkg SHALL hold:
- the state encoding;
- the GNT codes;
- the MEM_LAT default;
- the counter width (4).
REQ-028 The down-counter SHALL be a sub-module mar_arb_lat_cnt, with ports load, value, dec and count==1 flag.

Verification
REQ-029 Single fetch, MEM_LAT=2, FETCH_REQ high from cycle 0 -> LD_MAR_PC in cycle 1, MEM_RD in cycles 2-3, FETCH_ACK in cycle 4, GNT=01 in cycles 1-4.
REQ-030 Both requests at cycle 0, macro off, MEM_LAT=2 -> LD_MAR_MBR in cycle 1, OPER_ACK in cycle 4, then IDLE in cycle 5, LD_MAR_PC in cycle 6, FETCH_ACK in cycle 9.
REQ-031 Macro on, both requests held continuously (each re-raised after its ACK), starting from reset -> grant order fetch, operand, fetch, operand.
REQ-032 RST low during READ cycle 2 -> MEM_RD, GNT and BUSY are 0 before the next edge; after release, a fresh FETCH_REQ completes normally.
REQ-033 MEM_LAT=1, OPER_REQ dropped in cycle 2 -> LD_MAR_MBR in cycle 1, MEM_RD in cycle 2, OPER_ACK still issued in cycle 3.
REQ-034 Every scenario SHALL check that LD_MAR_PC and LD_MAR_MBR are never high together and that each ACK lasts exactly one cycle.

Source files
------------

// File: rtl/mar_arb_pkg.sv
// Shared definitions for the MAR arbiter: FSM state encoding, GNT codes,
// default memory latency and latency-counter width.
package mar_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_FETCH = 2'b01;
  localparam logic [1:0] GNT_OPER  = 2'b10;

  localparam int MEM_LAT_DEF = 2;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mar_arb_lat_cnt.sv
// Memory-latency down-counter: loaded at the start of a transaction,
// decremented during the read phase, flags when one cycle remains.
module mar_arb_lat_cnt
  import mar_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/mar_arb.sv
// MAR load arbiter between instruction-fetch and operand requests (Moore FSM).
// Define MAR_ARB_RR_EN for round-robin on simultaneous requests; default is operand-first.
module mar_arb
  import mar_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FETCH_REQ,
  input  logic       OPER_REQ,
  output logic       LD_MAR_PC,
  output logic       LD_MAR_MBR,
  output logic       MEM_RD,
  output logic       FETCH_ACK,
  output logic       OPER_ACK,
  output logic [1:0] GNT,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(MEM_LAT);

  state_t     state, state_nxt;
  logic [1:0] owner, winner;
  logic       any_req, cnt_one, lat_load, lat_dec;

  assign any_req = FETCH_REQ | OPER_REQ;

`ifdef MAR_ARB_RR_EN
  // last_oper remembers whether the operand side owned the previous grant
  logic last_oper;

  always_comb begin
    winner = GNT_FETCH;
    if (FETCH_REQ && OPER_REQ) begin
      winner = last_oper ? GNT_FETCH : GNT_OPER;
    end else if (OPER_REQ) begin
      winner = GNT_OPER;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_oper <= 1'b1;
    end else if (state == ST_IDLE && any_req) begin
      last_oper <= (winner == GNT_OPER);
    end
  end
`else
  assign winner = OPER_REQ ? GNT_OPER : GNT_FETCH;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      owner <= GNT_NONE;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        owner <= winner;
      end
    end
  end

  assign lat_load = (state == ST_LOAD);
  assign lat_dec  = (state == ST_READ);

  mar_arb_lat_cnt u_lat_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .load   (lat_load),
    .value  (LAT_VAL),
    .dec    (lat_dec),
    .is_one (cnt_one)
  );

  // Outputs depend only on state and the latched owner, so GNT holds from LOAD to ACK
  always_comb begin
    state_nxt  = state;
    LD_MAR_PC  = 1'b0;
    LD_MAR_MBR = 1'b0;
    MEM_RD     = 1'b0;
    FETCH_ACK  = 1'b0;
    OPER_ACK   = 1'b0;
    GNT        = GNT_NONE;
    BUSY       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        LD_MAR_PC  = (owner == GNT_FETCH);
        LD_MAR_MBR = (owner == GNT_OPER);
        GNT        = owner;
        BUSY       = 1'b1;
        state_nxt  = ST_READ;
      end
      ST_READ: begin
        MEM_RD = 1'b1;
        GNT    = owner;
        BUSY   = 1'b1;
        if (cnt_one) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        FETCH_ACK = (owner == GNT_FETCH);
        OPER_ACK  = (owner == GNT_OPER);
        GNT       = owner;
        BUSY      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
